// File: rtl/benes_pkg.sv
// benes_pkg: shared constants and types for the 16x16 Benes network control path.
package benes_pkg;
    localparam int N_PORTS      = 16;
    localparam int SW_PER_STAGE = N_PORTS / 2;
    localparam int STAGES       = 2 * $clog2(N_PORTS) - 1;
    localparam int CNT_W        = $clog2(STAGES);

    typedef logic [SW_PER_STAGE-1:0] stage_cfg_t;
    typedef stage_cfg_t [STAGES-1:0] net_cfg_t;
    typedef enum logic {LOAD, FULL} loader_state_t;
endpackage

// File: rtl/benes_cfg_loader.sv
// benes_cfg_loader: streams per-stage switch words into a shadow bank and
// commits the full network configuration atomically on a frame_sync boundary.
module benes_cfg_loader
    import benes_pkg::*;
(
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    cfg_valid,
    output logic                                    cfg_ready,
    input  logic [SW_PER_STAGE-1:0]                 cfg_data,
    input  logic                                    cfg_last,
    input  logic                                    frame_sync,
    output logic [STAGES-1:0][SW_PER_STAGE-1:0]     switch_set,
    output logic                                    commit_pulse,
    output logic                                    cfg_active,
    output logic                                    cfg_err
);
    loader_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    net_cfg_t         shadow_q, shadow_d;
    net_cfg_t         live_q, live_d;
    logic             commit_q, commit_d;
    logic             active_q, active_d;
    logic             err_q, err_d;
    logic             last_slot;

    assign last_slot = cnt_q == CNT_W'(STAGES - 1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        live_d   = live_q;
        commit_d = 1'b0;
        active_d = active_q;
        err_d    = 1'b0;
        if (state_q == LOAD && cfg_valid) begin
            shadow_d[cnt_q] = cfg_data;
            if (cfg_last && last_slot) begin
                state_d = FULL;
                cnt_d   = '0;
            end else if (cfg_last || last_slot) begin
                // Framing error: drop the partial load and restart at stage 0.
                err_d = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (state_q == FULL && frame_sync) begin
            live_d   = shadow_q;
            commit_d = 1'b1;
            active_d = 1'b1;
            state_d  = LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= LOAD;
            cnt_q    <= '0;
            shadow_q <= '0;
            live_q   <= '0;
            commit_q <= 1'b0;
            active_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            live_q   <= live_d;
            commit_q <= commit_d;
            active_q <= active_d;
            err_q    <= err_d;
        end
    end

    assign cfg_ready    = state_q == LOAD;
    assign switch_set   = live_q;
    assign commit_pulse = commit_q;
    assign cfg_active   = active_q;
    assign cfg_err      = err_q;
endmodule

// File: tb/tb_benes_cfg_loader.sv
// tb_benes_cfg_loader: table-driven nominal load plus directed multi-cycle
// sequences for held commit, framing errors, gaps and asynchronous reset.
module tb_benes_cfg_loader;
    import benes_pkg::*;

    typedef struct {
        logic       v;
        stage_cfg_t d;
        logic       l;
        logic       f;
        logic       rdy;
        logic       cp;
        logic       er;
        logic       act;
        net_cfg_t   sw;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    stage_cfg_t cfg_data = '0;
    logic       cfg_last = 1'b0;
    logic       frame_sync = 1'b0;
    net_cfg_t   switch_set;
    logic       commit_pulse;
    logic       cfg_active;
    logic       cfg_err;

    int n_cmp = 0;
    int n_bad = 0;

    benes_cfg_loader dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_data(cfg_data), .cfg_last(cfg_last), .frame_sync(frame_sync),
        .switch_set(switch_set), .commit_pulse(commit_pulse),
        .cfg_active(cfg_active), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    function automatic net_cfg_t fill(stage_cfg_t w);
        net_cfg_t r;
        for (int s = 0; s < STAGES; s++) r[s] = w;
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic outs(string name, logic rdy, logic cp, logic er, logic act, net_cfg_t sw);
        chk({name, ".ready"}, 64'(cfg_ready), 64'(rdy));
        chk({name, ".commit"}, 64'(commit_pulse), 64'(cp));
        chk({name, ".err"}, 64'(cfg_err), 64'(er));
        chk({name, ".active"}, 64'(cfg_active), 64'(act));
        chk({name, ".switch_set"}, 64'(switch_set), 64'(sw));
    endtask

    // Drive inputs away from the edge, then sample 1 time unit after it.
    task automatic step(logic v, stage_cfg_t d, logic l, logic f);
        @(negedge clk);
        cfg_valid  = v;
        cfg_data   = d;
        cfg_last   = l;
        frame_sync = f;
        @(posedge clk);
        #1;
    endtask

    task automatic load(stage_cfg_t w, logic f, string name, net_cfg_t live, logic act);
        for (int i = 0; i < STAGES; i++) begin
            step(1'b1, w, i == STAGES - 1, f);
            outs(name, i != STAGES - 1, 1'b0, 1'b0, act, live);
        end
    endtask

    vec_t     tbl[STAGES + 2];
    net_cfg_t nom;

    initial begin
        for (int i = 0; i < STAGES; i++) nom[i] = stage_cfg_t'(1 << i);
        for (int i = 0; i < STAGES; i++) begin
            tbl[i].v = 1'b1; tbl[i].d = nom[i]; tbl[i].l = (i == STAGES - 1); tbl[i].f = 1'b1;
            tbl[i].rdy = (i != STAGES - 1); tbl[i].cp = 1'b0; tbl[i].er = 1'b0;
            tbl[i].act = 1'b0; tbl[i].sw = '0;
        end
        for (int i = STAGES; i < STAGES + 2; i++) begin
            tbl[i].v = 1'b0; tbl[i].d = 8'hEE; tbl[i].l = 1'b1; tbl[i].f = 1'b1;
            tbl[i].rdy = 1'b1; tbl[i].cp = (i == STAGES); tbl[i].er = 1'b0;
            tbl[i].act = 1'b1; tbl[i].sw = nom;
        end

        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1 outs("reset", 1'b1, 1'b0, 1'b0, 1'b0, '0);

        for (int i = 0; i < STAGES + 2; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].f);
            outs($sformatf("nominal[%0d]", i), tbl[i].rdy, tbl[i].cp, tbl[i].er, tbl[i].act, tbl[i].sw);
        end

        load(8'hFF, 1'b0, "held_load", nom, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'hAA, 1'b0, 1'b0);
            outs("held_wait", 1'b0, 1'b0, 1'b0, 1'b1, nom);
        end
        step(1'b1, 8'hAA, 1'b0, 1'b1);
        outs("held_sync", 1'b1, 1'b1, 1'b0, 1'b1, fill(8'hFF));
        step(1'b0, 8'hAA, 1'b0, 1'b0);
        outs("held_after", 1'b1, 1'b0, 1'b0, 1'b1, fill(8'hFF));

        step(1'b1, 8'h11, 1'b0, 1'b1);
        step(1'b1, 8'h11, 1'b0, 1'b1);
        step(1'b1, 8'h11, 1'b1, 1'b1);
        outs("early_last_err", 1'b1, 1'b0, 1'b1, 1'b1, fill(8'hFF));
        step(1'b0, 8'h00, 1'b0, 1'b1);
        outs("early_last_clear", 1'b1, 1'b0, 1'b0, 1'b1, fill(8'hFF));
        load(8'h55, 1'b0, "early_reload", fill(8'hFF), 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        outs("early_commit", 1'b1, 1'b1, 1'b0, 1'b1, fill(8'h55));

        for (int i = 0; i < STAGES; i++) begin
            step(1'b1, 8'h77, 1'b0, 1'b1);
            outs("missing_last", 1'b1, 1'b0, i == STAGES - 1, 1'b1, fill(8'h55));
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        outs("missing_after", 1'b1, 1'b0, 1'b0, 1'b1, fill(8'h55));

        for (int i = 0; i < STAGES; i++) begin
            int gaps = $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) begin
                step(1'b0, 8'hC3, 1'b1, 1'b1);
                outs("gap_idle", 1'b1, 1'b0, 1'b0, 1'b1, fill(8'h55));
            end
            step(1'b1, stage_cfg_t'(8'h3C ^ i), i == STAGES - 1, 1'b1);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        begin
            net_cfg_t gx;
            for (int i = 0; i < STAGES; i++) gx[i] = stage_cfg_t'(8'h3C ^ i);
            outs("gap_commit", 1'b1, 1'b1, 1'b0, 1'b1, gx);
        end

        load(8'h0F, 1'b1, "pre_reset", switch_set, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        outs("pre_reset_commit", 1'b1, 1'b1, 1'b0, 1'b1, fill(8'h0F));
        for (int i = 0; i < 4; i++) step(1'b1, 8'h99, 1'b0, 1'b1);
        #2 rst = 1'b1;
        cfg_valid = 1'b0;
        #1 outs("async_reset", 1'b1, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        rst = 1'b0;
        load(8'h5A, 1'b1, "post_reset", '0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        outs("post_reset_commit", 1'b1, 1'b1, 1'b0, 1'b1, fill(8'h5A));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/benes_cfg_loader.md
Name: benes_cfg_loader

Overview:
- Produces the per-stage `switch_set` vectors that `stage_module` consumes. It is the writer side of the switch-control interface of the 16x16 Benes network.
- A host streams one 8-bit switch word per stage over a valid/ready handshake into a shadow bank.
- The complete 7-stage configuration is committed atomically to the live outputs on a `frame_sync` boundary, so the network never sees a half-updated route.
- Sits between the software/config path and the seven cascaded `stage_module` instances in the network top.

Parameters:
- N_PORTS, 16, network port count (power of two).
- SW_PER_STAGE, N_PORTS/2 = 8, 2x2 switches per stage (width of one `switch_set`).
- STAGES, 2*log2(N_PORTS)-1 = 7, number of Benes stages.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  host word valid.
- cfg_ready  out  1  loader can accept a word.
- cfg_data  in  SW_PER_STAGE  switch bits for the current stage; bit k = switch k; 1 = cross, 0 = bar.
- cfg_last  in  1  marks the final (stage STAGES-1) word of a configuration.
- frame_sync  in  1  commit permitted this cycle (data frame boundary).
- switch_set  out  STAGES x SW_PER_STAGE  live settings; element s drives `stage_module` s's `switch_set`.
- commit_pulse  out  1  one-cycle pulse, high in the cycle after a commit edge.
- cfg_active  out  1  a configuration has been committed since reset.
- cfg_err  out  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (asynchronous, `rst` = 1):
  - `switch_set` all 0 (every switch in bar/straight state), shadow bank all 0, word counter `cnt` = 0.
  - state = LOAD, `cfg_ready` = 1, `commit_pulse` = 0, `cfg_active` = 0, `cfg_err` = 0.
  - Reset asserted mid-load or mid-wait discards all progress.
- Handshake:
  - A word is accepted on a rising edge where `cfg_valid` && `cfg_ready`.
  - The host may insert idle cycles freely.
  - `cfg_data` and `cfg_last` are ignored when no word is accepted.
- State LOAD (`cfg_ready` = 1):
  - On accept: `shadow[cnt]` <= `cfg_data`.
  - If `cfg_last` && `cnt` == STAGES-1: go to FULL, `cnt` <= 0.
  - If `cfg_last` && `cnt` < STAGES-1 (early last): `cfg_err` pulse next cycle, `cnt` <= 0, stay in LOAD. The partial shadow contents are stale and are overwritten by the next load.
  - If !`cfg_last` && `cnt` == STAGES-1 (missing last): `cfg_err` pulse, `cnt` <= 0, stay in LOAD.
  - Otherwise `cnt` <= `cnt` + 1.
  - `frame_sync` is ignored in LOAD.
- State FULL (`cfg_ready` = 0):
  - `cfg_valid` is ignored; no word is accepted.
  - `frame_sync` is sampled on every edge while in FULL.
  - On the first edge with `frame_sync` = 1: `switch_set` <= shadow (all stages in the same edge), `commit_pulse` <= 1 for one cycle, `cfg_active` <= 1, state <= LOAD.
  - The earliest commit is the edge immediately after the last-word accept edge, i.e. 1-cycle minimum latency from last word to live output.
  - `frame_sync` held high continuously therefore commits at that next edge.
- `switch_set` changes only at a commit edge or on reset; the outputs are registered, so there are no combinational paths from inputs to `switch_set`.
- A new load may begin in the cycle after the commit. The shadow bank is overwritten while the live `switch_set` holds the previous configuration.
- `cfg_err` and `commit_pulse` can never assert in the same cycle.
- Counter width is clog2(STAGES) = 3 bits; values 7 and above are unreachable.

Decomposition:
- Shared package `benes_pkg`:
  - constants N_PORTS, SW_PER_STAGE, STAGES.
  - typedef `stage_cfg_t` (logic [SW_PER_STAGE-1:0]).
  - typedef `net_cfg_t` (`stage_cfg_t` [STAGES-1:0]).
  - enum `loader_state_t` {LOAD, FULL}.
- Single module; no sub-module is needed. The network top instantiates one `benes_cfg_loader` feeding STAGES `stage_module` instances.

Test Plan:
- Reset: assert `rst` asynchronously between clock edges -> immediately `switch_set` = 7 x 8'h00, `cfg_ready` = 1, `cfg_active` = 0, no pulses.
- Nominal load:
  - Stimulus: words 8'h01,02,04,08,10,20,40 back-to-back, `cfg_last` on the 7th, `frame_sync` held 1.
  - Required: `switch_set`[0..6] equals those values at the edge after the last accept; `commit_pulse` is high exactly one cycle; `cfg_active` = 1.
- Held commit:
  - Stimulus: load 8'hFF x7 with `frame_sync` = 0 for 5 cycles; drive `cfg_valid` = 1 with 8'hAA during the wait; then pulse `frame_sync` for one cycle.
  - Required: `cfg_ready` = 0 and `switch_set` unchanged during the wait; all stages become 8'hFF on the sync edge; the 8'hAA words are not captured.
- Early last: `cfg_last` on the 3rd word -> `cfg_err` one-cycle pulse, `switch_set` unchanged; a following correct 7-word load (8'h55 x7) commits 8'h55 to all stages.
- Missing last: 7 words with `cfg_last` = 0 -> `cfg_err` pulse after the 7th word, no commit, `cfg_ready` stays 1.
- Gapped input and reset mid-load:
  - Stimulus: a load with random `cfg_valid` gaps; then, after a commit of 8'h0F x7, assert `rst` after 4 words of a new load.
  - Required: the gapped load commits correctly; on reset `switch_set` returns to 8'h00 x7 and `cfg_active` = 0; the next full load commits cleanly.
